rx_control_unit: RTL
====================

Name: rx_control_unit

Overview:
Receive control unit for the UART RX datapath. It sequences one serial frame after the start-bit edge detector fires. It owns the bit-period timer and emits the strobes that drive the RX shift register, the stop-bit checker (sbc_clear / sbc_enable) and the RX data buffer. It sits between the edge detector / serial synchronizer and the RX datapath blocks.

Parameters:
CLKS_PER_BIT, 10, clock cycles per serial bit period; legal range 4..1023.
DATA_BITS, 8, data bits per frame; legal range 5..9.

Ports:
clk  input  1  system clock, all state on rising edge
n_rst  input  1  asynchronous active-low reset
start_bit_detected  input  1  one-cycle pulse from the start-bit edge detector
serial_in  input  1  synchronized serial line, used only for the start-bit validity check
framing_error  input  1  registered flag from the stop-bit checker
sbc_clear  output  1  one-cycle clear to the stop-bit checker
sbc_enable  output  1  one-cycle enable to the stop-bit checker at stop-bit mid-sample
shift_strobe  output  1  one-cycle shift enable to the RX shift register at each data-bit mid-sample
load_buffer  output  1  one-cycle load of the received byte into the RX data buffer
false_start  output  1  one-cycle pulse when the start bit reads 1 at its mid-sample
busy  output  1  high in every state except IDLE

Behaviour:
- Reset: asynchronous on n_rst low, including mid-frame.
  - State returns to IDLE.
  - clk_cnt = 0, bit_cnt = 0.
  - All outputs are 0.
- Counters:
  - clk_cnt is $clog2(CLKS_PER_BIT) bits wide and counts 0..CLKS_PER_BIT-1, then wraps to 0.
  - bit_cnt is $clog2(DATA_BITS+2) bits wide. It increments when clk_cnt wraps.
  - Slot 0 is the start bit, slots 1..DATA_BITS are data bits, slot DATA_BITS+1 is the stop bit.
  - MID = CLKS_PER_BIT/2 (integer division). Mid-sample of a slot is the cycle with clk_cnt == MID.
- Outputs are decoded from registered state and counters, so each is high for exactly one cycle per event.
- States and transitions:
  - IDLE: busy=0. start_bit_detected=1 -> CLEAR. Otherwise stay.
  - CLEAR: lasts one cycle. sbc_clear=1, clk_cnt=0, bit_cnt=0 -> RECEIVE. clk_cnt increments from the following cycle.
  - RECEIVE, slot 0 mid-sample:
    - serial_in=1: false_start=1 -> IDLE. No shift or load occurs.
    - serial_in=0: continue in RECEIVE.
  - RECEIVE, slots 1..DATA_BITS mid-sample: shift_strobe=1.
  - RECEIVE, slot DATA_BITS+1 mid-sample: sbc_enable=1 -> EVAL.
  - EVAL: lasts one cycle; framing_error now reflects this frame's stop bit.
    - framing_error=1 -> IDLE, no load.
    - framing_error=0 -> LOAD.
  - LOAD: lasts one cycle. load_buffer=1 -> IDLE.
- Latency (T = cycle in which start_bit_detected is sampled high):
  - CLEAR at T+1.
  - Mid-sample of slot k at T+1+CLKS_PER_BIT*k+MID.
  - EVAL one cycle after the sbc_enable cycle; LOAD one cycle after EVAL.
- The frame ends (return to IDLE) before the stop bit finishes. A start edge arriving after that is accepted normally.
- start_bit_detected is ignored in every state except IDLE. No queuing.
- serial_in is ignored outside the slot-0 mid-sample.
- framing_error is ignored outside EVAL.
- Only one of sbc_clear / sbc_enable / shift_strobe / load_buffer / false_start is high in any cycle.

Test Plan:
1. Reset: n_rst low while clk toggles -> all outputs 0, busy 0. Then pulse n_rst low at T+40 during a frame -> next cycle in IDLE with outputs 0, and no load_buffer follows.
2. Valid frame, defaults (start pulse at T, serial_in low at T+6, framing_error 0):
   - sbc_clear at T+1.
   - shift_strobe at T+16, T+26, ..., T+86 (8 pulses).
   - sbc_enable at T+96.
   - load_buffer at T+98.
   - busy low from T+99.
3. Framing error: same as 2, but the checker model drives framing_error=1 from T+97 -> no load_buffer pulse, busy low from T+98.
4. False start: serial_in=1 at T+6 -> false_start at T+6, no shift_strobe, busy low at T+7.
5. Ignored start: extra start_bit_detected pulses at T+30 and T+50 -> sequence identical to scenario 2. A new pulse at T+99 is accepted, with sbc_clear at T+100.
6. Parameter sweep CLKS_PER_BIT=4, DATA_BITS=5 (MID=2):
   - sbc_clear at T+1.
   - shift_strobe at T+7, T+11, T+15, T+19, T+23.
   - sbc_enable at T+27.
   - load_buffer at T+29.

Source files
------------

// File: rtl/rx_control_unit.sv
// Receive control unit: sequences one UART frame after a start-bit edge,
// owning the bit-period timer and the strobes for the RX datapath blocks.
module rx_control_unit #(
  parameter int CLKS_PER_BIT = 10,
  parameter int DATA_BITS    = 8
) (
  input  logic clk,
  input  logic n_rst,
  input  logic start_bit_detected,
  input  logic serial_in,
  input  logic framing_error,
  output logic sbc_clear,
  output logic sbc_enable,
  output logic shift_strobe,
  output logic load_buffer,
  output logic false_start,
  output logic busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_BITS + 2);
  localparam logic [CW-1:0] MID       = CW'(CLKS_PER_BIT / 2);
  localparam logic [CW-1:0] LAST      = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] STOP_SLOT = BW'(DATA_BITS + 1);

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    RECEIVE,
    EVAL,
    LOAD
  } state_t;

  state_t          state, next_state;
  logic [CW-1:0]   clk_cnt, next_clk_cnt;
  logic [BW-1:0]   bit_cnt, next_bit_cnt;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state   <= IDLE;
      clk_cnt <= '0;
      bit_cnt <= '0;
    end else begin
      state   <= next_state;
      clk_cnt <= next_clk_cnt;
      bit_cnt <= next_bit_cnt;
    end
  end

  // The CLEAR cycle doubles as clk_cnt==0 of the start slot, so counting
  // resumes at 1 on entry to RECEIVE. Counters rest at zero outside a frame.
  always_comb begin
    next_state   = state;
    next_clk_cnt = '0;
    next_bit_cnt = '0;
    sbc_clear    = 1'b0;
    sbc_enable   = 1'b0;
    shift_strobe = 1'b0;
    load_buffer  = 1'b0;
    false_start  = 1'b0;
    busy         = (state != IDLE);

    case (state)
      IDLE: begin
        if (start_bit_detected) next_state = CLEAR;
      end
      CLEAR: begin
        sbc_clear    = 1'b1;
        next_clk_cnt = CW'(1);
        next_state   = RECEIVE;
      end
      RECEIVE: begin
        if (clk_cnt == LAST) begin
          next_clk_cnt = '0;
          next_bit_cnt = bit_cnt + 1'b1;
        end else begin
          next_clk_cnt = clk_cnt + 1'b1;
          next_bit_cnt = bit_cnt;
        end
        if (clk_cnt == MID) begin
          if (bit_cnt == '0) begin
            if (serial_in) begin
              false_start  = 1'b1;
              next_state   = IDLE;
              next_clk_cnt = '0;
              next_bit_cnt = '0;
            end
          end else if (bit_cnt == STOP_SLOT) begin
            sbc_enable   = 1'b1;
            next_state   = EVAL;
            next_clk_cnt = '0;
            next_bit_cnt = '0;
          end else begin
            shift_strobe = 1'b1;
          end
        end
      end
      EVAL: begin
        next_state = framing_error ? IDLE : LOAD;
      end
      LOAD: begin
        load_buffer = 1'b1;
        next_state  = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

endmodule
